// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode/funct encodings, instruction classes,
// field positions and the registered field bundle carried through the stage.
package decode_pkg;

   localparam int unsigned OPC_W   = 6;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned FUNCT_W = 6;
   localparam int unsigned IMM_W   = 16;
   localparam int unsigned TGT_W   = 26;
   localparam int unsigned CLS_W   = 3;

   localparam int unsigned OPC_LSB   = 26;
   localparam int unsigned RD_LSB    = 21;
   localparam int unsigned RT_LSB    = 16;
   localparam int unsigned RS_LSB    = 11;
   localparam int unsigned SHAMT_LSB = 6;
   localparam int unsigned FUNCT_LSB = 0;
   localparam int unsigned IMM_LSB   = 0;
   localparam int unsigned TGT_LSB   = 0;

   localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OPC_W-1:0] OP_J     = 6'h02;
   localparam logic [OPC_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OPC_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OPC_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OPC_W-1:0] OP_SLTI  = 6'h0A;
   localparam logic [OPC_W-1:0] OP_ANDI  = 6'h0C;
   localparam logic [OPC_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [OPC_W-1:0] OP_XORI  = 6'h0E;
   localparam logic [OPC_W-1:0] OP_LW    = 6'h23;
   localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

   localparam logic [FUNCT_W-1:0] FN_SLL = 6'h00;
   localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
   localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
   localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
   localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
   localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

   typedef enum logic [CLS_W-1:0] {
      CLS_R       = 3'd0,
      CLS_I_ALU   = 3'd1,
      CLS_LOAD    = 3'd2,
      CLS_STORE   = 3'd3,
      CLS_BRANCH  = 3'd4,
      CLS_JUMP    = 3'd5,
      CLS_ILLEGAL = 3'd7
   } instr_class_e;

   typedef struct packed {
      logic [OPC_W-1:0]   opcode;
      logic [REG_W-1:0]   rd;
      logic [REG_W-1:0]   rt;
      logic [REG_W-1:0]   rs;
      logic [REG_W-1:0]   shamt;
      logic [FUNCT_W-1:0] funct;
      logic [TGT_W-1:0]   target;
      instr_class_e       cls;
      logic               illegal;
   } dec_fields_t;

   function automatic logic funct_legal(input logic [FUNCT_W-1:0] f);
      return f inside {FN_SLL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
   endfunction

endpackage

// File: rtl/decode_comb.sv
// Pure combinational decode: field split, classification and immediate
// extension of one instruction word.
module decode_comb
   import decode_pkg::*;
#(
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned DATA_W  = 32
) (
   input  logic [INSTR_W-1:0] instr_i,
   output dec_fields_t        fields_o,
   output logic [DATA_W-1:0]  imm_ext_o
);

   logic [OPC_W-1:0]   opcode;
   logic [FUNCT_W-1:0] funct;
   logic [IMM_W-1:0]   imm;
   instr_class_e       cls;
   logic               zext;

   assign opcode = instr_i[OPC_LSB +: OPC_W];
   assign funct  = instr_i[FUNCT_LSB +: FUNCT_W];
   assign imm    = instr_i[IMM_LSB +: IMM_W];

   // Logical-immediate ops zero-extend; everything else sign-extends.
   always_comb begin
      cls  = CLS_ILLEGAL;
      zext = 1'b0;
      case (opcode)
         OP_RTYPE:                 cls = funct_legal(funct) ? CLS_R : CLS_ILLEGAL;
         OP_ADDI, OP_SLTI:         cls = CLS_I_ALU;
         OP_ANDI, OP_ORI, OP_XORI: begin
            cls  = CLS_I_ALU;
            zext = 1'b1;
         end
         OP_LW:                    cls = CLS_LOAD;
         OP_SW:                    cls = CLS_STORE;
         OP_BEQ, OP_BNE:           cls = CLS_BRANCH;
         OP_J:                     cls = CLS_JUMP;
         default:                  cls = CLS_ILLEGAL;
      endcase

      imm_ext_o              = {DATA_W{zext ? 1'b0 : imm[IMM_W-1]}};
      imm_ext_o[IMM_W-1:0]   = imm;
   end

   always_comb begin
      fields_o         = '0;
      fields_o.opcode  = opcode;
      fields_o.rd      = instr_i[RD_LSB +: REG_W];
      fields_o.rt      = instr_i[RT_LSB +: REG_W];
      fields_o.rs      = instr_i[RS_LSB +: REG_W];
      fields_o.shamt   = instr_i[SHAMT_LSB +: REG_W];
      fields_o.funct   = funct;
      fields_o.target  = instr_i[TGT_LSB +: TGT_W];
      fields_o.cls     = cls;
      fields_o.illegal = (cls == CLS_ILLEGAL);
   end

endmodule

// File: rtl/decode_stage.sv
// Registered decode pipeline stage: output register plus skid register for
// full throughput under backpressure, synchronous flush, transfer counter.
module decode_stage
   import decode_pkg::*;
#(
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [5:0]         out_opcode,
   output logic [4:0]         out_rd,
   output logic [4:0]         out_rt,
   output logic [4:0]         out_rs,
   output logic [4:0]         out_shamt,
   output logic [5:0]         out_funct,
   output logic [DATA_W-1:0]  out_imm_ext,
   output logic [25:0]        out_target,
   output logic [2:0]         out_class,
   output logic               out_illegal,
   output logic [CNT_W-1:0]   decoded_count
);

   dec_fields_t       dec_fields;
   logic [DATA_W-1:0] dec_imm;

   dec_fields_t       or_q, or_d, sk_q, sk_d;
   logic [DATA_W-1:0] or_imm_q, or_imm_d, sk_imm_q, sk_imm_d;
   logic              or_valid_q, or_valid_d, sk_valid_q, sk_valid_d;
   logic              in_ready_q, in_ready_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              accept, xfer;

   decode_comb #(
      .INSTR_W (INSTR_W),
      .DATA_W  (DATA_W)
   ) u_decode_comb (
      .instr_i   (in_instr),
      .fields_o  (dec_fields),
      .imm_ext_o (dec_imm)
   );

   assign accept = in_valid & in_ready_q;
   assign xfer   = or_valid_q & out_ready;

   // Skid-buffer steering; ready is re-registered from the next SK state.
   always_comb begin
      or_d       = or_q;
      or_imm_d   = or_imm_q;
      sk_d       = sk_q;
      sk_imm_d   = sk_imm_q;
      or_valid_d = or_valid_q;
      sk_valid_d = sk_valid_q;
      cnt_d      = cnt_q;
      if (flush) begin
         or_valid_d = 1'b0;
         sk_valid_d = 1'b0;
      end else begin
         if (xfer) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         if (xfer && sk_valid_q) begin
            or_d       = sk_q;
            or_imm_d   = sk_imm_q;
            sk_valid_d = 1'b0;
         end else if (accept && (xfer || !or_valid_q)) begin
            or_d       = dec_fields;
            or_imm_d   = dec_imm;
            or_valid_d = 1'b1;
         end else if (accept) begin
            sk_d       = dec_fields;
            sk_imm_d   = dec_imm;
            sk_valid_d = 1'b1;
         end else if (xfer) begin
            or_valid_d = 1'b0;
         end
      end
      in_ready_d = ~sk_valid_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         or_q       <= '0;
         or_imm_q   <= '0;
         sk_q       <= '0;
         sk_imm_q   <= '0;
         or_valid_q <= 1'b0;
         sk_valid_q <= 1'b0;
         in_ready_q <= 1'b1;
         cnt_q      <= '0;
      end else begin
         or_q       <= or_d;
         or_imm_q   <= or_imm_d;
         sk_q       <= sk_d;
         sk_imm_q   <= sk_imm_d;
         or_valid_q <= or_valid_d;
         sk_valid_q <= sk_valid_d;
         in_ready_q <= in_ready_d;
         cnt_q      <= cnt_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign out_valid     = or_valid_q;
   assign out_opcode    = or_q.opcode;
   assign out_rd        = or_q.rd;
   assign out_rt        = or_q.rt;
   assign out_rs        = or_q.rs;
   assign out_shamt     = or_q.shamt;
   assign out_funct     = or_q.funct;
   assign out_imm_ext   = or_imm_q;
   assign out_target    = or_q.target;
   assign out_class     = CLS_W'(or_q.cls);
   assign out_illegal   = or_q.illegal;
   assign decoded_count = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a scoreboard of expected decoded words
// (counter narrowed to 2 bits so wrap is reachable).
module tb_decode_stage;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned CNT_W   = 2;

   logic               clk = 1'b0;
   logic               reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [INSTR_W-1:0] in_instr;
   logic [5:0]         out_opcode, out_funct;
   logic [4:0]         out_rd, out_rt, out_rs, out_shamt;
   logic [DATA_W-1:0]  out_imm_ext;
   logic [25:0]        out_target;
   logic [2:0]         out_class;
   logic               out_illegal;
   logic [CNT_W-1:0]   decoded_count;
   logic [31:0]        obs_word;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm;
      logic [2:0]  cls;
      logic        ill;
   } exp_t;

   exp_t sb[$];
   int   checks  = 0;
   int   errors  = 0;
   int   exp_cnt = 0;

   localparam logic [31:0] W_AND  = 32'h0109_8024;
   localparam logic [31:0] W_SUB  = 32'h0109_9022;
   localparam logic [31:0] W_ADDI = 32'h2108_FFFF;
   localparam logic [31:0] W_ORI  = 32'h3508_FFFF;
   localparam logic [31:0] W_BADOP = 32'hFC00_0000;
   localparam logic [31:0] W_BADFN = 32'h0000_0021;

   decode_stage #(
      .INSTR_W (INSTR_W),
      .DATA_W  (DATA_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_opcode    (out_opcode),
      .out_rd        (out_rd),
      .out_rt        (out_rt),
      .out_rs        (out_rs),
      .out_shamt     (out_shamt),
      .out_funct     (out_funct),
      .out_imm_ext   (out_imm_ext),
      .out_target    (out_target),
      .out_class     (out_class),
      .out_illegal   (out_illegal),
      .decoded_count (decoded_count)
   );

   always #5 clk = ~clk;

   assign obs_word = {out_opcode, out_rd, out_rt, out_rs, out_shamt, out_funct};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t ref_decode(input logic [31:0] w);
      exp_t        e;
      logic [5:0]  op, fn;
      logic [15:0] im;
      op = w[31:26];
      fn = w[5:0];
      im = w[15:0];
      e.instr = w;
      if (op == 6'h00)
         e.cls = (fn == 6'h00 || fn == 6'h20 || fn == 6'h22 || fn == 6'h24 ||
                  fn == 6'h25 || fn == 6'h2A) ? 3'd0 : 3'd7;
      else if (op == 6'h08 || op == 6'h0A || op == 6'h0C || op == 6'h0D || op == 6'h0E)
         e.cls = 3'd1;
      else if (op == 6'h23) e.cls = 3'd2;
      else if (op == 6'h2B) e.cls = 3'd3;
      else if (op == 6'h04 || op == 6'h05) e.cls = 3'd4;
      else if (op == 6'h02) e.cls = 3'd5;
      else e.cls = 3'd7;
      e.ill = (e.cls == 3'd7);
      if (op >= 6'h0C && op <= 6'h0E) e.imm = {16'h0000, im};
      else e.imm = {{16{im[15]}}, im};
      return e;
   endfunction

   // Scoreboard: push on accept, pop and compare on transfer.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         sb.delete();
         exp_cnt = 0;
      end else if (flush) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_out", 64'(sb.size()), 64'd1);
            end else begin
               e = sb.pop_front();
               check("sb_word",    obs_word,    e.instr);
               check("sb_target",  out_target,  64'(e.instr[25:0]));
               check("sb_imm",     out_imm_ext, e.imm);
               check("sb_class",   out_class,   e.cls);
               check("sb_illegal", out_illegal, e.ill);
               exp_cnt = (exp_cnt + 1) % 4;
            end
         end
         if (in_valid && in_ready) sb.push_back(ref_decode(in_instr));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] w);
      in_valid = 1'b1;
      in_instr = w;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) step();
      check("drain_timeout", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_instr = 32'hDEAD_BEEF; out_ready = 1'b1;
      step(); step();
      reset = 1'b0; in_valid = 1'b0; in_instr = '0;

      check("rst_in_ready",  in_ready,      1);
      check("rst_out_valid", out_valid,     0);
      check("rst_count",     decoded_count, 0);
      check("rst_word",      obs_word,      0);
      check("rst_target",    out_target,    0);
      check("rst_imm",       out_imm_ext,   0);
      check("rst_class",     out_class,     0);
      check("rst_illegal",   out_illegal,   0);

      // AND: one-cycle latency, fields, count on transfer
      send(W_AND);
      check("and_valid",   out_valid,     1);
      check("and_opcode",  out_opcode,    0);
      check("and_rd",      out_rd,        8);
      check("and_rt",      out_rt,        9);
      check("and_rs",      out_rs,        16);
      check("and_funct",   out_funct,     6'h24);
      check("and_class",   out_class,     0);
      check("and_illegal", out_illegal,   0);
      check("and_cnt0",    decoded_count, 0);
      step();
      check("and_cnt1",    decoded_count, 1);
      check("and_empty",   out_valid,     0);

      // Immediate extension
      send(W_ADDI);
      check("addi_imm",   out_imm_ext, 32'hFFFF_FFFF);
      check("addi_class", out_class,   1);
      check("addi_rd",    out_rd,      8);
      check("addi_rt",    out_rt,      8);
      send(W_ORI);
      check("ori_imm",    out_imm_ext, 32'h0000_FFFF);
      check("ori_class",  out_class,   1);
      check("ori_rd",     out_rd,      8);
      check("ori_rt",     out_rt,      8);

      // Illegal encodings
      send(W_BADOP);
      check("badop_class",   out_class,   7);
      check("badop_illegal", out_illegal, 1);
      send(W_BADFN);
      check("badfn_class",   out_class,   7);
      check("badfn_illegal", out_illegal, 1);
      step();
      wait_drain();
      check("wrap_count_5", decoded_count, 1);

      // Backpressure through the skid register
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = W_AND;
      step();
      check("bp_ready_a", in_ready,  1);
      check("bp_valid_a", out_valid, 1);
      check("bp_word_a",  obs_word,  W_AND);
      in_instr = W_SUB;
      step();
      check("bp_ready_b", in_ready, 0);
      check("bp_hold_b",  obs_word, W_AND);
      in_instr = W_ADDI;
      step();
      check("bp_ready_c", in_ready,  0);
      check("bp_hold_c",  obs_word,  W_AND);
      check("bp_valid_c", out_valid, 1);
      out_ready = 1'b1;
      step();
      check("bp_word_b",   obs_word, W_SUB);
      check("bp_ready_re", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("bp_word_c", obs_word,    W_ADDI);
      check("bp_imm_c",  out_imm_ext, 32'hFFFF_FFFF);
      step();
      wait_drain();
      check("bp_count", decoded_count, 0);
      check("bp_count_model", decoded_count, 64'(exp_cnt));

      // Flush with OR and SK full, transfer in the flush cycle
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = W_AND;
      step();
      in_instr = W_SUB;
      step();
      check("fl_full", in_ready, 0);
      in_instr = W_ORI; flush = 1'b1; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("fl_valid", out_valid,     0);
      check("fl_ready", in_ready,      1);
      check("fl_count", decoded_count, 0);
      step(); step();
      check("fl_no_ghost", out_valid, 0);

      // Flush drops a word presented while ready
      out_ready = 1'b0;
      send(W_SUB);
      in_valid = 1'b1; in_instr = W_ORI; flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("fl2_valid", out_valid, 0);
      out_ready = 1'b1;
      step();
      check("fl2_no_ghost", out_valid,     0);
      check("fl2_count",    decoded_count, 0);

      // Reset wins over flush with both buffers full and a nonzero count
      send(W_AND);
      step();
      check("rp_pre_count", decoded_count, 1);
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = W_ADDI;
      step();
      in_instr = W_SUB;
      step();
      reset = 1'b1; flush = 1'b1; in_instr = W_ORI;
      step();
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
      check("rp_valid",   out_valid,     0);
      check("rp_ready",   in_ready,      1);
      check("rp_count",   decoded_count, 0);
      check("rp_word",    obs_word,      0);
      check("rp_imm",     out_imm_ext,   0);
      check("rp_target",  out_target,    0);
      check("rp_class",   out_class,     0);
      check("rp_illegal", out_illegal,   0);
      out_ready = 1'b1;
      send(W_BADFN);
      check("rp_after_word", obs_word, W_BADFN);
      step();
      wait_drain();
      check("rp_after_count", decoded_count, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
